hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Parametrised, stateful successor to the single-cycle decode-stage hazard logic.
- Detects load-use hazards and stalls for a configurable number of cycles, which supports multi-cycle data memory.
- Resolves decode-stage branches with selectable conditions (BGT/BEQ/BNE) and flushes for a configurable number of cycles.
- Keeps saturating stall/flush event counters for performance analysis.
- Sits between the decode stage and the IF/ID and ID/EX pipeline registers.

Parameters:
- DATA_W, 16, width of register-file operands compared for branches.
- REG_ADDR_W, 5, register address width.
- OPCODE_W, 5, opcode width.
- OP_NOP, 5'b00000, nop opcode.
- OP_BGT, 5'b00011, branch if operand_a > operand_b (unsigned).
- OP_BEQ, 5'b00100, branch if equal.
- OP_BNE, 5'b00101, branch if not equal.
- LOAD_STALL_CYCLES, 1, bubbles per load-use hazard; legal range 1..7.
- FLUSH_CYCLES, 1, cycles flush_fd is held per taken branch; legal range 1..3.
- ZERO_REG_HARDWIRED, 1, if 1 then rd_execute==0 never creates a hazard.
- CNT_W, 16, event counter width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- opcode_decode, input, OPCODE_W, opcode of the instruction in decode.
- rs1_decode, input, REG_ADDR_W, source register 1 in decode.
- rs2_decode, input, REG_ADDR_W, source register 2 in decode.
- rs1_used, input, 1, decode instruction reads rs1.
- rs2_used, input, 1, decode instruction reads rs2.
- rd_execute, input, REG_ADDR_W, destination register in execute.
- load_execute, input, 1, execute-stage instruction is a load.
- operand_a, input, DATA_W, register-file read data 1.
- operand_b, input, DATA_W, register-file read data 2.
- cnt_clr, input, 1, synchronous clear of both counters.
- stall_fd, output, 1, hold PC and IF/ID register.
- bubble_de, output, 1, load a nop into ID/EX.
- flush_fd, output, 1, zero the IF/ID register.
- branch_taken, output, 1, one-cycle pulse on branch resolution.
- state_o, output, 2, current FSM state (00 IDLE, 01 LSTALL, 10 FLUSH).
- stall_events, output, CNT_W, count of load-use hazard events.
- flush_events, output, CNT_W, count of taken branches.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, stall/flush down-counter=0. All outputs are 0 while in reset.
- Hazard condition, evaluated in IDLE only:
  - hz = load_execute & opcode_decode!=OP_NOP & ((rs1_used & rs1_decode==rd_execute) | (rs2_used & rs2_decode==rd_execute)).
  - hz is masked when ZERO_REG_HARDWIRED and rd_execute==0.
- Branch condition, evaluated in IDLE only:
  - BGT: operand_a>operand_b, unsigned, DATA_W wide.
  - BEQ: operand_a==operand_b.
  - BNE: operand_a!=operand_b.
  - bt = (opcode is one of the three branch opcodes) & its condition holds.
- Priority: hz beats bt. A branch whose operand depends on a load stalls first and is re-evaluated after the stall with correct data. A nop opcode never produces hz or bt.
- IDLE, on hz (Mealy, same cycle):
  - stall_fd=1, bubble_de=1, stall_events increments.
  - If LOAD_STALL_CYCLES>1: go to LSTALL with down-counter = LOAD_STALL_CYCLES-2.
- LSTALL:
  - stall_fd=1, bubble_de=1; inputs are ignored.
  - Down-counter decrements each cycle; at 0, go to IDLE at the next edge.
  - Total assertion = exactly LOAD_STALL_CYCLES consecutive cycles.
- IDLE, on bt with no hz (same cycle):
  - flush_fd=1, branch_taken=1, flush_events increments.
  - If FLUSH_CYCLES>1: go to FLUSH with down-counter = FLUSH_CYCLES-2.
- FLUSH:
  - flush_fd=1, branch_taken=0.
  - hz and bt are ignored because the instructions are being squashed.
  - Exits like LSTALL; total flush_fd assertion = FLUSH_CYCLES cycles.
- stall_fd and flush_fd are never both 1.
- Back-to-back hazards:
  - After returning to IDLE, evaluation resumes in the first IDLE cycle.
  - A second hazard with no IDLE gap is impossible by construction; the FSM must still re-detect it if presented.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Reset mid-LSTALL/FLUSH: outputs drop to 0 immediately (async); the FSM is in IDLE after rst_n rises.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0, then release with opcode=OP_NOP, load_execute=1, rd_execute=rs1_decode=3.
  - Required: all outputs 0; counters stay 0.
- Load-use, LOAD_STALL_CYCLES=3:
  - Stimulus: load_execute=1, rd_execute=7, rs2_decode=7, rs2_used=1, opcode=ADD.
  - Required: stall_fd=bubble_de=1 for exactly 3 cycles; state_o goes 00→01→01→00; stall_events=1.
- Branch, FLUSH_CYCLES=2:
  - Stimulus: OP_BGT with operand_a=16'h0005, operand_b=16'h0003.
  - Required: branch_taken pulses 1 cycle; flush_fd=1 for 2 cycles; flush_events=1.
  - Also: operand_a=3, operand_b=5 → no flush; OP_BEQ with 16'hFFFF==16'hFFFF → taken.
- Load feeding branch:
  - Stimulus: OP_BNE, rs1_decode=4=rd_execute, load_execute=1, operand_a!=operand_b.
  - Required: stall first with no flush during the stall; next IDLE cycle with load_execute=0 and operands differing → flush; stall_events=1, flush_events=1.
- Zero register and unused source:
  - Stimulus: rd_execute=0 matching rs1, or rs1 match with rs1_used=0.
  - Required: no stall.
- Reset mid-stall and counters:
  - Stimulus: assert rst_n=0 in the 2nd LSTALL cycle.
  - Required: outputs 0 immediately.
  - Stimulus: with CNT_W=2, run 5 stall events.
  - Required: stall_events=3 (saturated); cnt_clr coincident with an event gives 0.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Decode-stage hazard bus: decode/execute information in, pipeline controls
// and performance counters out. The pipeline drives it as master; the hazard
// unit is the slave.
interface hazard_control_unit_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 5,
    parameter int CNT_W      = 16
);
    logic [OPCODE_W-1:0]   opcode_decode;
    logic [REG_ADDR_W-1:0] rs1_decode;
    logic [REG_ADDR_W-1:0] rs2_decode;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd_execute;
    logic                  load_execute;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic                  cnt_clr;

    logic                  stall_fd;
    logic                  bubble_de;
    logic                  flush_fd;
    logic                  branch_taken;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_events;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output opcode_decode, rs1_decode, rs2_decode, rs1_used, rs2_used,
               rd_execute, load_execute, operand_a, operand_b, cnt_clr,
        input  stall_fd, bubble_de, flush_fd, branch_taken, state_o,
               stall_events, flush_events
    );

    modport slave (
        input  opcode_decode, rs1_decode, rs2_decode, rs1_used, rs2_used,
               rd_execute, load_execute, operand_a, operand_b, cnt_clr,
        output stall_fd, bubble_de, flush_fd, branch_taken, state_o,
               stall_events, flush_events
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard control: detects load-use hazards (multi-cycle stall),
// resolves decode-stage branches (multi-cycle flush) and keeps saturating
// stall/flush event counters. Hazard and branch decisions are Mealy in IDLE
// so the first stall/flush cycle coincides with the offending instruction.
module hazard_control_unit #(
    parameter int                 DATA_W             = 16,
    parameter int                 REG_ADDR_W         = 5,
    parameter int                 OPCODE_W           = 5,
    parameter logic [OPCODE_W-1:0] OP_NOP            = 5'b00000,
    parameter logic [OPCODE_W-1:0] OP_BGT            = 5'b00011,
    parameter logic [OPCODE_W-1:0] OP_BEQ            = 5'b00100,
    parameter logic [OPCODE_W-1:0] OP_BNE            = 5'b00101,
    parameter int                 LOAD_STALL_CYCLES  = 1,
    parameter int                 FLUSH_CYCLES       = 1,
    parameter int                 ZERO_REG_HARDWIRED = 1,
    parameter int                 CNT_W              = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LSTALL = 2'b01,
        S_FLUSH  = 2'b10
    } state_t;

    // The first stall/flush cycle is spent in IDLE, so the down-counter is
    // preloaded with the remaining cycles minus one (exit when it reads 0).
    localparam logic [2:0] LSTALL_INIT = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
    localparam logic [2:0] FLUSH_INIT  = (FLUSH_CYCLES > 1)      ? 3'(FLUSH_CYCLES - 2)      : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_next;
    logic [CNT_W-1:0]      r_stall_events;
    logic [CNT_W-1:0]      r_flush_events;

    logic [REG_ADDR_W-1:0] w_src_addr [2];
    logic                  w_src_used [2];
    logic [1:0]            w_src_match;
    logic                  w_rd_masked;
    logic                  w_hz;
    logic                  w_cond;
    logic                  w_bt;
    logic                  w_stall;
    logic                  w_flush;
    logic                  w_branch_pulse;
    logic                  w_inc_stall;
    logic                  w_inc_flush;

    assign w_src_addr[0] = bus.rs1_decode;
    assign w_src_addr[1] = bus.rs2_decode;
    assign w_src_used[0] = bus.rs1_used;
    assign w_src_used[1] = bus.rs2_used;

    // One comparator per decode source operand against the load destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_src_match[gi] = w_src_used[gi] && (w_src_addr[gi] == bus.rd_execute);
        end
    endgenerate

    // A load into a hardwired zero register produces nothing to wait for.
    assign w_rd_masked = (ZERO_REG_HARDWIRED != 0) && (bus.rd_execute == '0);
    assign w_hz = bus.load_execute && (bus.opcode_decode != OP_NOP)
                  && (|w_src_match) && !w_rd_masked;

    // Branch condition selected by opcode; non-branch opcodes (incl. nop) never take.
    always_comb begin
        w_cond = 1'b0;
        case (bus.opcode_decode)
            OP_BGT:  w_cond = (bus.operand_a > bus.operand_b);
            OP_BEQ:  w_cond = (bus.operand_a == bus.operand_b);
            OP_BNE:  w_cond = (bus.operand_a != bus.operand_b);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_bt = w_cond;

    // State register and stall/flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and control outputs; hazard beats branch, and both are
    // only looked at in IDLE (stall/flush windows ignore decode contents).
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_stall        = 1'b0;
        w_flush        = 1'b0;
        w_branch_pulse = 1'b0;
        w_inc_stall    = 1'b0;
        w_inc_flush    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hz) begin
                    w_stall     = 1'b1;
                    w_inc_stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_state_next = S_LSTALL;
                        w_cnt_next   = LSTALL_INIT;
                    end
                end else if (w_bt) begin
                    w_flush        = 1'b1;
                    w_branch_pulse = 1'b1;
                    w_inc_flush    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next = S_FLUSH;
                        w_cnt_next   = FLUSH_INIT;
                    end
                end
            end
            S_LSTALL: begin
                w_stall = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // Saturating event counters; a clear wins over a coincident event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_events <= '0;
            r_flush_events <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_events <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_inc_stall && (r_stall_events != CNT_MAX)) begin
                r_stall_events <= r_stall_events + CNT_W'(1);
            end
            if (w_inc_flush && (r_flush_events != CNT_MAX)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    // Mealy outputs are gated by rst_n so they drop the moment reset asserts,
    // even though the decode inputs may still describe a hazard.
    assign bus.stall_fd     = w_stall && rst_n;
    assign bus.bubble_de    = w_stall && rst_n;
    assign bus.flush_fd     = w_flush && rst_n;
    assign bus.branch_taken = w_branch_pulse && rst_n;
    assign bus.state_o      = r_state;
    assign bus.stall_events = r_stall_events;
    assign bus.flush_events = r_flush_events;

endmodule
